// File: rtl/delay_inv_bank.sv
// Bank of independent inverting channels with separate rise/fall/turn-off delays.
// Each channel follows inertial-delay semantics: short target changes are absorbed.
module delay_inv_bank #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RISE  = 2,
    parameter int unsigned FALL  = 4,
    parameter int unsigned OFF   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] ctrl,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] oe,
    output logic [WIDTH-1:0] busy
);

    localparam int unsigned MAXRF = (RISE > FALL) ? RISE : FALL;
    localparam int unsigned MAXD  = (MAXRF > OFF) ? MAXRF : OFF;
    localparam int unsigned CW    = $clog2(MAXD + 1);

    localparam logic [CW-1:0] D_RISE = CW'(RISE);
    localparam logic [CW-1:0] D_FALL = CW'(FALL);
    localparam logic [CW-1:0] D_OFF  = CW'(OFF);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [WIDTH-1:0] out_q, oe_q, busy_q;
    logic [WIDTH-1:0] pend_out, pend_oe;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] t_out, t_oe;

    function automatic logic [CW-1:0] sel_delay(input logic oe_t, input logic out_t);
        if (!oe_t)
            return D_OFF;
        return out_t ? D_RISE : D_FALL;
    endfunction

    // A disabled target leaves the driven value untouched.
    always_comb begin
        t_oe  = ctrl;
        t_out = out_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (ctrl[i])
                t_out[i] = ~in[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            oe_q     <= '0;
            busy_q   <= '0;
            pend_out <= '0;
            pend_oe  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (busy_q[i]) begin
                    if (t_oe[i] == pend_oe[i] && t_out[i] == pend_out[i]) begin
                        if (cnt[i] == ONE) begin
                            oe_q[i]   <= pend_oe[i];
                            out_q[i]  <= pend_out[i];
                            busy_q[i] <= 1'b0;
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] - ONE;
                        end
                    end else if (t_oe[i] == oe_q[i] && t_out[i] == out_q[i]) begin
                        busy_q[i] <= 1'b0;
                        cnt[i]    <= '0;
                    end else begin
                        pend_oe[i]  <= t_oe[i];
                        pend_out[i] <= t_out[i];
                        cnt[i]      <= sel_delay(t_oe[i], t_out[i]);
                    end
                end else if (t_oe[i] != oe_q[i] || t_out[i] != out_q[i]) begin
                    pend_oe[i]  <= t_oe[i];
                    pend_out[i] <= t_out[i];
                    busy_q[i]   <= 1'b1;
                    cnt[i]      <= sel_delay(t_oe[i], t_out[i]);
                end
            end
        end
    end

    assign out  = out_q;
    assign oe   = oe_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_delay_inv_bank.sv
// Vector-table bench for delay_inv_bank (WIDTH=4, RISE=2, FALL=4, OFF=6).
// Expected states are queued when each vector is driven and compared after the edge.
module tb_delay_inv_bank;

    typedef struct {
        logic       rst_n;
        logic [3:0] in;
        logic [3:0] ctrl;
        logic [3:0] out;
        logic [3:0] oe;
        logic [3:0] busy;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] out;
        logic [3:0] oe;
        logic [3:0] busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_s;
    logic [3:0] ctrl_s;
    logic [3:0] out_s, oe_s, busy_s;

    vec_t vecs1[$];
    vec_t vecs2[$];
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   vid = 0;

    delay_inv_bank #(.WIDTH(4), .RISE(2), .FALL(4), .OFF(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in_s),
        .ctrl (ctrl_s),
        .out  (out_s),
        .oe   (oe_s),
        .busy (busy_s)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic add1(input logic r, input logic [3:0] i, input logic [3:0] c,
                        input logic [3:0] o, input logic [3:0] e, input logic [3:0] b,
                        input int n);
        for (int k = 0; k < n; k++) vecs1.push_back('{r, i, c, o, e, b});
    endtask

    task automatic add2(input logic r, input logic [3:0] i, input logic [3:0] c,
                        input logic [3:0] o, input logic [3:0] e, input logic [3:0] b,
                        input int n);
        for (int k = 0; k < n; k++) vecs2.push_back('{r, i, c, o, e, b});
    endtask

    task automatic check_now(input string name, input logic [3:0] eo,
                             input logic [3:0] ee, input logic [3:0] eb);
        checks++;
        if (out_s === eo && oe_s === ee && busy_s === eb)
            passed++;
        else
            $display("FAIL %s: out/oe/busy got %b/%b/%b expected %b/%b/%b",
                     name, out_s, oe_s, busy_s, eo, ee, eb);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        check_now($sformatf("vec%0d", e.id), e.out, e.oe, e.busy);
    endtask

    task automatic apply(input vec_t v);
        rst_n  = v.rst_n;
        in_s   = v.in;
        ctrl_s = v.ctrl;
        sb.push_back('{vid, v.out, v.oe, v.busy});
        vid++;
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        // Phase 1: turn-on, fall/rise, glitch, turn-off cancel, turn-off, multi-channel turn-on, FALL on ch1
        add1(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1);
        add1(1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 2);
        add1(1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 1);
        add1(1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4);
        add1(1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 6);
        add1(1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 2);
        add1(1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 1);
        add1(1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 3);
        add1(1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 3);
        add1(1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 3);
        add1(1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4);
        add1(1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 6);
        add1(1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 2);
        add1(1, 4'h0, 4'h7, 4'h1, 4'h0, 4'h7, 2);
        add1(1, 4'h0, 4'h7, 4'h7, 4'h7, 4'h0, 1);
        add1(1, 4'h2, 4'h7, 4'h7, 4'h7, 4'h2, 1);
        // Phase 2: after reset, no late transition; fresh turn-on; restart FALL->OFF on ch3
        add2(1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add2(1, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 2);
        add2(1, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 1);
        add2(1, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 1);
        add2(1, 4'h8, 4'h0, 4'h8, 4'h8, 4'h8, 6);
        add2(1, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 1);

        rst_n  = 1'b0;
        in_s   = 4'h0;
        ctrl_s = 4'h0;
        #1;
        check_now("reset_initial", 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs1.size(); i++) apply(vecs1[i]);

        // Asynchronous reset between edges while a FALL event is pending on ch1
        #2;
        rst_n = 1'b0;
        #1;
        check_now("reset_async", 4'h0, 4'h0, 4'h0);
        ctrl_s = 4'h0;
        @(posedge clk);
        #1;
        check_now("reset_held_edge", 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs2.size(); i++) apply(vecs2[i]);

        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/delay_inv_bank.md
DELAY_INV_BANK -- requirements
Module: delay_inv_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent inverter channels (1..32).
REQ-002 Parameter RISE, default 2: clock cycles from sampled cause to the output going to 1 (1..255).
REQ-003 Parameter FALL, default 4: clock cycles from sampled cause to the output going to 0 (1..255).
REQ-004 Parameter OFF, default 6: clock cycles from sampled cause to the output being disabled (1..255).
REQ-005 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port in, input, WIDTH bits: per-channel data input.
REQ-008 Port ctrl, input, WIDTH bits: per-channel enable; 1 means drive the inverted input, 0 means disable.
REQ-009 Port out, output, WIDTH bits: per-channel registered delayed output value.
REQ-010 Port oe, output, WIDTH bits: per-channel output enable; 0 is the high-Z equivalent.
REQ-011 Port busy, output, WIDTH bits: 1 while a channel has a pending, not yet applied transition.

Function
REQ-012 Each channel's target SHALL be as follows: ctrl[i]=1 gives target (oe=1, out=~in[i]); ctrl[i]=0 gives target (oe=0, out unchanged).
REQ-013 Each channel SHALL keep the state: current (oe, out), pending target, and a down-counter of width ceil(log2(max(RISE,FALL,OFF)+1)).
REQ-014 The target SHALL be sampled at every rising edge; channels are fully independent.
REQ-015 Delay selection SHALL be: target oe=0 with current oe=1 uses OFF; target out=1 with oe=1 uses RISE; target out=0 with oe=1 uses FALL.
REQ-016 Turn-on from the disabled state SHALL use RISE or FALL according to the new out value.
REQ-017 In an enabled-to-enabled transition, the output SHALL keep its current value while the channel is pending.
REQ-018 If the target sampled at edge k differs from the current (oe, out) and no pending event exists, the channel SHALL load delay D, set busy, and apply the target at edge k+D (latency exactly D cycles).
REQ-019 Inertial rule, restart: if the sampled target changes while pending and differs from the current output, the channel SHALL restart the counter with the delay for the new target, counted from that edge.
REQ-020 Inertial rule, cancel: if the sampled target changes while pending and equals the current output, the channel SHALL cancel the pending event and clear busy at that edge, with no output change.
REQ-021 A stable target SHALL NOT retrigger a channel while it is pending.
REQ-022 Glitch rejection: an input pulse shorter than the applicable delay SHALL never reach out or oe.
REQ-023 busy[i] SHALL be 1 from the loading edge through the cycle before the apply edge, and 0 on the apply or cancel edge.
REQ-024 While oe[i]=0, out[i] SHALL hold its last driven value.
REQ-025 Simultaneous in and ctrl changes on one channel SHALL be evaluated as a single combined target under REQ-012..REQ-020.
REQ-026 The counter SHALL never wrap; a counter reaching 0 applies the event exactly once.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force out=0, oe=0 and busy=0, clear all counters and discard all pending events.
REQ-028 After rst_n is released, the first edge SHALL sample targets normally, with no state carried over from before reset.
REQ-029 Reset asserted mid-pending SHALL cancel the pending event, which is never applied afterwards.

Verification (WIDTH=4, RISE=2, FALL=4, OFF=6)
REQ-030 Reset: rst_n=0 between edges -> out=0, oe=0, busy=0 asynchronously, before the next clk edge.
REQ-031 Turn-on: ctrl[0]=1, in[0]=0 sampled at edge k -> busy[0]=1 at k, oe[0]=1 and out[0]=1 at k+2; other channels unchanged.
REQ-032 Fall then rise: with ch0 enabled and out=1, in[0] 0->1 sampled at k -> out[0]=0 at k+4; in[0] 1->0 at k+10 -> out[0]=1 at k+12.
REQ-033 Glitch: with out[0]=1, in[0]=1 for 3 cycles then back to 0 -> out[0] stays 1; busy[0] high for 3 cycles and cleared on the cancel edge.
REQ-034 Turn-off: ctrl[0] 1->0 sampled at k with out[0]=1 -> oe[0]=0 at k+6 and out[0] still 1; ctrl[0] back to 1 at k+3 -> pending cancelled and oe[0] stays 1.
REQ-035 Reset mid-pending plus multi-channel: ch1 and ch2 turned on at the same edge, both apply at k+2 independently; then a FALL event pending on ch1 with rst_n pulsed at k+1 -> all outputs 0 and no late transition at k+4.
